// File: rtl/tpmem_param.sv
// tpmem_param: parametrised true two-port synchronous RAM with registered
// read data, per-port read-valid strobes, a post-reset clear sweep and a
// registered same-address collision flag.
// Optional feature macro: TPMEM_BYPASS_EN (write-first read data when a read
// coincides with a write to the same address); undefined gives read-first.
module tpmem_param #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic              a_we,
  input  logic              a_re,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_rvalid,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  input  logic              b_we,
  input  logic              b_re,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_rvalid,
  output logic              busy,
  output logic              collision
);

  // Array index width; addresses at or above DEPTH are screened out before
  // the index is ever used for a write, and reads of them return zero.
  localparam int                IDX_W    = $clog2(DEPTH);
  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0]  LAST_PTR = IDX_W'(DEPTH - 1);

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              a_in, b_in, same_addr;
  logic [IDX_W-1:0]  a_idx, b_idx;
  logic              a_wr, b_wr, a_rd, b_rd;
  logic [DATA_W-1:0] a_rdata_d, b_rdata_d;
  logic              collision_d;

  logic [DATA_W-1:0] a_rdata_q, b_rdata_q;
  logic              a_rvalid_q, b_rvalid_q, collision_q;

  assign busy = (state_q == ST_CLEAR);

  // Request decode: range screening and qualification by the clear engine.
  assign a_in      = ({1'b0, a_addr} < DEPTH_L);
  assign b_in      = ({1'b0, b_addr} < DEPTH_L);
  assign a_idx     = a_addr[IDX_W-1:0];
  assign b_idx     = b_addr[IDX_W-1:0];
  assign same_addr = (a_addr == b_addr);
  assign a_wr      = !busy && a_we && a_in;
  assign b_wr      = !busy && b_we && b_in;
  assign a_rd      = !busy && a_re;
  assign b_rd      = !busy && b_re;

  // Clear-engine state register; reset always restarts the sweep at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Clear-engine next state: walk ptr over every word, leave after the last.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_CLEAR: begin
        ptr_d = ptr_q + IDX_W'(1);
        if (ptr_q == LAST_PTR) begin
          state_d = ST_RUN;
          ptr_d   = '0;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Array writes: the sweep owns the array while busy; otherwise port A is
  // applied last so it wins a same-address write/write.
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[ptr_q] <= '0;
    end else begin
      if (b_wr) mem[b_idx] <= b_wdata;
      if (a_wr) mem[a_idx] <= a_wdata;
    end
  end

  // Read-data selection, including the optional same-cycle write forwarding.
  always_comb begin
    a_rdata_d = a_in ? mem[a_idx] : '0;
    b_rdata_d = b_in ? mem[b_idx] : '0;
`ifdef TPMEM_BYPASS_EN
    if (a_wr) begin
      a_rdata_d = a_wdata;
    end else if (b_wr && same_addr) begin
      a_rdata_d = b_wdata;
    end
    if (a_wr && same_addr) begin
      b_rdata_d = a_wdata;
    end else if (b_wr) begin
      b_rdata_d = b_wdata;
    end
`endif
  end

  // Collision detect: a cross-port same-address conflict involving a write;
  // a_in together with same_addr implies both addresses are in range.
  always_comb begin
    collision_d = !busy && a_in && same_addr &&
                  ((a_we && b_we) || (a_re && b_we) || (b_re && a_we));
  end

  // ---- stage boundary: registered read data, valid strobes, collision ----
  // Output registers; rdata holds between reads, valid and collision pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
      a_rvalid_q  <= 1'b0;
      b_rvalid_q  <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      a_rvalid_q  <= a_rd;
      b_rvalid_q  <= b_rd;
      collision_q <= collision_d;
      if (a_rd) a_rdata_q <= a_rdata_d;
      if (b_rd) b_rdata_q <= b_rdata_d;
    end
  end

  assign a_rdata   = a_rdata_q;
  assign b_rdata   = b_rdata_q;
  assign a_rvalid  = a_rvalid_q;
  assign b_rvalid  = b_rvalid_q;
  assign collision = collision_q;

endmodule

// File: doc/tpmem_param.md
# tpmem_param

Parametrised true two-port synchronous RAM for the multicycle processor's shared instruction/data memory. Two independent read/write ports, each with registered read data and a read-valid strobe. A hardware clear engine zeroes the array after reset. Same-address collisions resolve deterministically and are flagged. Instantiated in place of the fixed 16-bit two-port memory wherever width, depth or collision behaviour must be controlled.

## Interface
Parameters:
- DATA_W, 16, word width in bits
- ADDR_W, 16, address width in bits
- DEPTH, 1<<ADDR_W, number of words; must be ≤ 2^ADDR_W and ≥ 2

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- a_addr  in  ADDR_W  port A word address
- a_wdata  in  DATA_W  port A write data
- a_we  in  1  port A write enable
- a_re  in  1  port A read enable
- a_rdata  out  DATA_W  port A registered read data
- a_rvalid  out  1  port A read-data-valid pulse
- b_addr, b_wdata, b_we, b_re, b_rdata, b_rvalid: same as port A, for port B
- busy  out  1  clear engine active; all requests ignored
- collision  out  1  one-cycle pulse on a same-address conflict

## Operation
- Reset, asynchronous: a_rdata, b_rdata = 0; a_rvalid, b_rvalid, collision = 0; busy = 1; clear pointer = 0. The array itself is not reset asynchronously.
- Clear engine (busy = 1):
  - Writes 0 to address ptr each cycle, ptr = 0..DEPTH-1.
  - After the write to DEPTH-1, busy drops to 0 on the next edge.
  - All port requests are ignored while busy: no writes, rvalid stays 0, collision stays 0.
  - Reset asserted mid-sweep restarts the sweep at ptr = 0.
- Write: on an edge with we = 1 and busy = 0, mem[addr] ← wdata.
- Read: on an edge with re = 1 and busy = 0, rdata ← mem[addr] and rvalid = 1 for one cycle. rdata holds its value when re = 0.
- Out-of-range address (addr ≥ DEPTH):
  - Writes are dropped.
  - Reads return 0, with rvalid still asserted.
- Same-address write/write (a_we & b_we, a_addr == b_addr, in range): port A's data is stored and collision pulses.
- Same-address read/write across ports (one port reads, the other writes the same in-range address): collision pulses. Returned data is governed by the bypass configuration below.
- A port reading and writing its own address in the same cycle is not a collision. Returned data follows the same bypass rule.
- Out-of-range addresses never raise collision.

## Timing
- Read latency is 1 cycle: request sampled at edge N; rdata and rvalid valid after edge N and held through edge N+1.
- A write is visible to reads issued on the next cycle (edge N+1).
- collision is registered and asserts after the edge at which the conflicting requests were sampled, for exactly one cycle.
- busy lasts exactly DEPTH cycles after reset deasserts.
- Both ports sustain one request per cycle with no stalls.

## Configuration
- TPMEM_BYPASS_EN defined (write-first):
  - A read that coincides with any write to the same address returns the data actually stored that cycle.
  - That data is port A's wdata whenever a_we hits the address, otherwise port B's wdata.
- Not defined (read-first):
  - Such reads return the pre-write contents.
- Collision flagging is identical in both builds.

## Test plan
- Reset sweep: DATA_W=16, DEPTH=8. Deassert reset. busy must stay 1 for exactly 8 cycles. A read of addr 5 issued while busy must give rvalid = 0. A read after busy drops must return 0x0000.
- Basic ports: A writes 0x1234 @3 while B writes 0xBEEF @4. Next cycle A reads @4 and B reads @3. One cycle later: a_rdata = 0xBEEF, b_rdata = 0x1234, both rvalid = 1, collision = 0.
- Write/write collision: A writes 0xAAAA @2 and B writes 0x5555 @2 on the same edge. collision pulses for 1 cycle. A subsequent read @2 returns 0xAAAA.
- Read/write collision: mem[6] = 0x0011. A writes 0x00FF @6 while B reads @6. collision = 1. b_rdata = 0x00FF with TPMEM_BYPASS_EN, 0x0011 without it.
- Out-of-range: DEPTH=6, ADDR_W=3. A write 0x7777 @7 is dropped. A read @7 returns 0 with rvalid = 1. Simultaneous A and B writes @7 give collision = 0.
- Reset mid-sweep: assert reset at ptr = 3 and release. busy must then last a full DEPTH cycles from release, and a_rvalid and b_rvalid must stay 0 throughout.
